magnitude_scan_controller: RTL and testbench
============================================

MAGNITUDE_SCAN_CONTROLLER -- requirements
Module: magnitude_scan_controller

Interface
REQ-001 Parameter DATA_WIDTH, default 24, width of each real/imaginary FFT component and of the magnitude.
REQ-002 Parameter ADDR_WIDTH, default 10, FFT bin RAM address width.
REQ-003 Parameter NUM_BINS, default 512, bins scanned per frame, indices 0..NUM_BINS-1; legal range 1..2^ADDR_WIDTH.
REQ-004 clk  in  1  single system clock; all logic on rising edge.
REQ-005 reset  in  1  synchronous, active-low reset (0 = reset).
REQ-006 i_fft_done  in  1  one-cycle pulse: new FFT frame available in the bin RAM.
REQ-007 o_busy  out  1  high from scan start until the cycle after o_frame_done.
REQ-008 o_bin_rd_en  out  1  bin RAM read strobe.
REQ-009 o_bin_rd_addr  out  ADDR_WIDTH  bin RAM read address.
REQ-010 i_bin_rd_data  in  2*DATA_WIDTH  {re, im} signed; valid exactly one cycle after o_bin_rd_en.
REQ-011 o_mag_start  out  1  to magnitude_approximator i_start.
REQ-012 o_mag_complex  out  2*DATA_WIDTH  to magnitude_approximator i_fft_complex.
REQ-013 i_mag_valid  in  1  from magnitude_approximator o_valid.
REQ-014 i_magnitude  in  DATA_WIDTH  from magnitude_approximator o_magnitude, unsigned.
REQ-015 o_spec_wr_en  out  1  spectrum buffer write strobe.
REQ-016 o_spec_wr_addr  out  ADDR_WIDTH  spectrum buffer write address.
REQ-017 o_spec_wr_data  out  DATA_WIDTH  magnitude written.
REQ-018 o_frame_done  out  1  one-cycle pulse: all NUM_BINS magnitudes written.
REQ-019 o_peak_bin  out  ADDR_WIDTH  bin index of the largest magnitude in the last completed frame.
REQ-020 o_peak_mag  out  DATA_WIDTH  magnitude at o_peak_bin.
REQ-021 o_overrun  out  1  sticky flag: i_fft_done received while busy.

Function
REQ-022 FSM states IDLE, READ, DRAIN, DONE; reset state IDLE.
REQ-023 IDLE -> READ on i_fft_done; read counter, write counter, running peak cleared to 0 in that cycle.
REQ-024 READ: o_bin_rd_en=1 every cycle, o_bin_rd_addr = read counter (0,1,...,NUM_BINS-1); after issuing address NUM_BINS-1 -> DRAIN.
REQ-025 o_mag_start SHALL be o_bin_rd_en delayed by one register; o_mag_complex SHALL equal i_bin_rd_data (combinational, aligned with o_mag_start).
REQ-026 Throughput one bin per clock; no bubbles between consecutive reads.
REQ-027 Write path is driven only by i_mag_valid, independent of approximator latency: each i_mag_valid cycle registers o_spec_wr_en=1, o_spec_wr_data=i_magnitude, o_spec_wr_addr=write counter, then increments the write counter.
REQ-028 End-to-end latency with the 3-cycle approximator: o_bin_rd_en at cycle t -> o_spec_wr_en at t+5.
REQ-029 DRAIN -> DONE when the write counter reaches NUM_BINS; i_mag_valid in IDLE or DONE is ignored (no write, no counter change).
REQ-030 DONE lasts exactly one cycle: o_frame_done=1, o_peak_bin/o_peak_mag loaded from the running peak; then -> IDLE.
REQ-031 Running peak updates only when i_magnitude > running peak (strict); ties keep the lower bin index; an all-zero frame yields bin 0, mag 0.
REQ-032 o_peak_bin/o_peak_mag hold their value between frames and change only in DONE.
REQ-033 i_fft_done in READ, DRAIN or DONE is ignored for scanning and sets o_overrun; o_overrun clears only on reset.
REQ-034 NUM_BINS=1: READ lasts one cycle; counters compare against NUM_BINS without wrap for NUM_BINS=2^ADDR_WIDTH (counters ADDR_WIDTH+1 bits).

Reset
REQ-035 While reset=0 at a clock edge: state IDLE, all counters 0, all strobes/pulses 0, o_bin_rd_addr/o_spec_wr_addr/o_spec_wr_data 0, o_peak_bin/o_peak_mag 0, o_overrun 0, o_busy 0.
REQ-036 Reset asserted mid-scan aborts the frame: no o_frame_done, no further writes after reset deasserts; late i_mag_valid pulses from the approximator are ignored in IDLE.

Verification (bench: DUT + magnitude_approximator + behavioural bin RAM, NUM_BINS=8)
REQ-037 Bins all (1000,0), i_fft_done pulse -> 8 writes of 1000 to addr 0..7, o_frame_done 1 cycle after 8th write, peak bin 0 mag 1000.
REQ-038 Bin k = (100*k, 0), bin 5 = (0,-2000) -> write addr 5 data 2000, peak bin 5 mag 2000; bins 3 and 4 (300,400) -> 550 per approximator rounding.
REQ-039 First read at cycle t -> first o_spec_wr_en at t+5; wr_en high 8 consecutive cycles.
REQ-040 i_fft_done again during DRAIN -> o_overrun=1 and stays 1, current frame completes normally, no second scan starts.
REQ-041 reset=0 for one cycle after 3rd read -> all outputs to REQ-035 values, no writes or o_frame_done follow; next i_fft_done runs a complete clean frame.
REQ-042 All bins zero -> 8 writes of 0, peak bin 0 mag 0; previous frame's peak retained until this frame's DONE.

Source files
------------

// File: rtl/magnitude_scan_controller.sv
// Magnitude scan controller: walks the FFT bin RAM one bin per clock,
// feeds each {re, im} pair to the magnitude approximator, writes the
// returned magnitudes to the spectrum buffer and tracks the frame peak.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for i_fft_done; late approximator results ignored
// S_READ  | one bin RAM read per cycle, addresses 0..NUM_BINS-1
// S_DRAIN | reads finished, waiting for the remaining magnitudes
// S_DONE  | single cycle: frame_done pulse, peak registers loaded
module magnitude_scan_controller #(
  parameter int DATA_WIDTH = 24,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_BINS   = 512
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_fft_done,
  output logic                    o_busy,
  output logic                    o_bin_rd_en,
  output logic [ADDR_WIDTH-1:0]   o_bin_rd_addr,
  input  logic [2*DATA_WIDTH-1:0] i_bin_rd_data,
  output logic                    o_mag_start,
  output logic [2*DATA_WIDTH-1:0] o_mag_complex,
  input  logic                    i_mag_valid,
  input  logic [DATA_WIDTH-1:0]   i_magnitude,
  output logic                    o_spec_wr_en,
  output logic [ADDR_WIDTH-1:0]   o_spec_wr_addr,
  output logic [DATA_WIDTH-1:0]   o_spec_wr_data,
  output logic                    o_frame_done,
  output logic [ADDR_WIDTH-1:0]   o_peak_bin,
  output logic [DATA_WIDTH-1:0]   o_peak_mag,
  output logic                    o_overrun
);

  // One extra bit so NUM_BINS = 2^ADDR_WIDTH is representable without wrap.
  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] LAST_BIN  = CW'(NUM_BINS - 1);
  localparam logic [CW-1:0] BIN_COUNT = CW'(NUM_BINS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         rd_cnt;
  logic [CW-1:0]         wr_cnt;
  logic [ADDR_WIDTH-1:0] peak_bin_run;
  logic [DATA_WIDTH-1:0] peak_mag_run;
  logic                  frame_start;
  logic                  wr_accept;

  assign frame_start = (state == S_IDLE) && i_fft_done;
  // Results only count while a frame is in flight; the counter guard keeps
  // stray extra valids from wrapping the write address.
  assign wr_accept   = i_mag_valid && ((state == S_READ) || (state == S_DRAIN))
                       && (wr_cnt != BIN_COUNT);

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_fft_done)            state_nxt = S_READ;
      S_READ:  if (rd_cnt == LAST_BIN)    state_nxt = S_DRAIN;
      S_DRAIN: if (wr_cnt == BIN_COUNT)   state_nxt = S_DONE;
      S_DONE:                             state_nxt = S_IDLE;
      default:                            state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs; the read address is forced to 0 outside READ.
  always_comb begin
    o_bin_rd_en   = (state == S_READ);
    o_bin_rd_addr = (state == S_READ) ? rd_cnt[ADDR_WIDTH-1:0] : '0;
    o_busy        = (state != S_IDLE);
    o_frame_done  = (state == S_DONE);
  end

  // RAM data arrives one cycle after the strobe, so the delayed strobe lines
  // up with the combinational pass-through of the read data.
  assign o_mag_complex = i_bin_rd_data;

  // Read counter and approximator start strobe.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_cnt      <= '0;
      o_mag_start <= 1'b0;
    end else begin
      o_mag_start <= o_bin_rd_en;
      if (frame_start)            rd_cnt <= '0;
      else if (state == S_READ)   rd_cnt <= rd_cnt + CW'(1);
    end
  end

  // Spectrum write path and running peak, driven purely by i_mag_valid.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_cnt         <= '0;
      o_spec_wr_en   <= 1'b0;
      o_spec_wr_addr <= '0;
      o_spec_wr_data <= '0;
      peak_bin_run   <= '0;
      peak_mag_run   <= '0;
    end else begin
      o_spec_wr_en <= 1'b0;
      if (frame_start) begin
        wr_cnt       <= '0;
        peak_bin_run <= '0;
        peak_mag_run <= '0;
      end else if (wr_accept) begin
        o_spec_wr_en   <= 1'b1;
        o_spec_wr_addr <= wr_cnt[ADDR_WIDTH-1:0];
        o_spec_wr_data <= i_magnitude;
        wr_cnt         <= wr_cnt + CW'(1);
        // Strict compare: on a tie the earlier (lower) bin wins.
        if (i_magnitude > peak_mag_run) begin
          peak_mag_run <= i_magnitude;
          peak_bin_run <= wr_cnt[ADDR_WIDTH-1:0];
        end
      end
    end
  end

  // Published peak changes only at the end of a completed frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_peak_bin <= '0;
      o_peak_mag <= '0;
    end else if (state == S_DONE) begin
      o_peak_bin <= peak_bin_run;
      o_peak_mag <= peak_mag_run;
    end
  end

  // Sticky overrun: a new frame arrived before the current scan returned to IDLE.
  always_ff @(posedge clk) begin
    if (!reset)                               o_overrun <= 1'b0;
    else if (i_fft_done && (state != S_IDLE)) o_overrun <= 1'b1;
  end

endmodule

// File: tb/tb_magnitude_scan_controller.sv
// Directed bench: DUT with a behavioural bin RAM and a 3-cycle
// alpha-max-plus-half-min magnitude approximator, NUM_BINS = 8.
module tb_magnitude_scan_controller;

  localparam int DW = 24;
  localparam int AW = 10;
  localparam int NB = 8;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            i_fft_done = 1'b0;
  logic            o_busy, o_bin_rd_en, o_mag_start, o_spec_wr_en, o_frame_done, o_overrun;
  logic [AW-1:0]   o_bin_rd_addr, o_spec_wr_addr, o_peak_bin;
  logic [2*DW-1:0] i_bin_rd_data = '0;
  logic [2*DW-1:0] o_mag_complex;
  logic            i_mag_valid;
  logic [DW-1:0]   i_magnitude, o_spec_wr_data, o_peak_mag;

  magnitude_scan_controller #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_BINS(NB)) dut (
    .clk(clk), .reset(reset), .i_fft_done(i_fft_done), .o_busy(o_busy),
    .o_bin_rd_en(o_bin_rd_en), .o_bin_rd_addr(o_bin_rd_addr), .i_bin_rd_data(i_bin_rd_data),
    .o_mag_start(o_mag_start), .o_mag_complex(o_mag_complex),
    .i_mag_valid(i_mag_valid), .i_magnitude(i_magnitude),
    .o_spec_wr_en(o_spec_wr_en), .o_spec_wr_addr(o_spec_wr_addr), .o_spec_wr_data(o_spec_wr_data),
    .o_frame_done(o_frame_done), .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag),
    .o_overrun(o_overrun)
  );

  always #5 clk = ~clk;

  // Behavioural bin RAM, one-cycle read latency.
  logic [2*DW-1:0] bin_ram [NB];
  always @(posedge clk) if (o_bin_rd_en) i_bin_rd_data <= bin_ram[o_bin_rd_addr[2:0]];

  // Approximator model: max(|re|,|im|) + min(|re|,|im|)/2, three cycles.
  function automatic logic [DW-1:0] approx(input logic [2*DW-1:0] c);
    logic signed [DW-1:0] re, im;
    logic [DW-1:0] a, b;
    re = c[2*DW-1:DW];
    im = c[DW-1:0];
    a = (re < 0) ? DW'(-re) : DW'(re);
    b = (im < 0) ? DW'(-im) : DW'(im);
    return (a > b) ? a + (b >> 1) : b + (a >> 1);
  endfunction

  logic v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
  logic [DW-1:0] m1 = '0, m2 = '0, m3 = '0;
  always @(posedge clk) begin
    v1 <= o_mag_start; m1 <= approx(o_mag_complex);
    v2 <= v1;          m2 <= m1;
    v3 <= v2;          m3 <= m2;
  end
  assign i_mag_valid = v3;
  assign i_magnitude = m3;

  // Observation log, sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rd_seen = 0, wr_seen = 0, fd_seen = 0;
  int first_rd = 0, first_wr = 0, last_wr = 0, fd_cyc = 0;
  logic [AW-1:0] wa [16];
  logic [DW-1:0] wd [16];
  always @(negedge clk) begin
    if (o_bin_rd_en) begin
      if (rd_seen == 0) first_rd = cyc;
      rd_seen++;
    end
    if (o_spec_wr_en) begin
      if (wr_seen < 16) begin
        wa[wr_seen] = o_spec_wr_addr;
        wd[wr_seen] = o_spec_wr_data;
      end
      if (wr_seen == 0) first_wr = cyc;
      last_wr = cyc;
      wr_seen++;
    end
    if (o_frame_done) begin
      fd_seen++;
      fd_cyc = cyc;
    end
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    rd_seen = 0; wr_seen = 0; fd_seen = 0;
  endtask

  task automatic pulse_fft();
    i_fft_done = 1'b1;
    step();
    i_fft_done = 1'b0;
  endtask

  task automatic wait_frame(input string tag);
    for (int i = 0; i < 60 && fd_seen == 0; i++) step();
    chk({tag, " frame_done count"}, 64'(fd_seen), 64'd1);
    step();
  endtask

  task automatic check_writes(input string tag, input int e[NB]);
    chk({tag, " write count"}, 64'(wr_seen), 64'd8);
    for (int i = 0; i < NB; i++) begin
      chk($sformatf("%s wr_addr[%0d]", tag, i), 64'(wa[i]), 64'(i));
      chk($sformatf("%s wr_data[%0d]", tag, i), 64'(wd[i]), 64'(e[i]));
    end
    chk({tag, " read-to-write latency"}, 64'(first_wr - first_rd), 64'd5);
    chk({tag, " write burst span"}, 64'(last_wr - first_wr), 64'd7);
    chk({tag, " frame_done after last write"}, 64'(fd_cyc - last_wr), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " busy"}, 64'(o_busy), 64'd0);
    chk({tag, " rd_en"}, 64'(o_bin_rd_en), 64'd0);
    chk({tag, " rd_addr"}, 64'(o_bin_rd_addr), 64'd0);
    chk({tag, " mag_start"}, 64'(o_mag_start), 64'd0);
    chk({tag, " wr_en"}, 64'(o_spec_wr_en), 64'd0);
    chk({tag, " wr_addr"}, 64'(o_spec_wr_addr), 64'd0);
    chk({tag, " wr_data"}, 64'(o_spec_wr_data), 64'd0);
    chk({tag, " frame_done"}, 64'(o_frame_done), 64'd0);
    chk({tag, " peak_bin"}, 64'(o_peak_bin), 64'd0);
    chk({tag, " peak_mag"}, 64'(o_peak_mag), 64'd0);
    chk({tag, " overrun"}, 64'(o_overrun), 64'd0);
  endtask

  task automatic set_bin(input int k, input int re, input int im);
    logic [31:0] r, m;
    r = re; m = im;
    bin_ram[k] = {r[DW-1:0], m[DW-1:0]};
  endtask

  int exp_flat[NB] = '{1000, 1000, 1000, 1000, 1000, 1000, 1000, 1000};
  int exp_ramp[NB] = '{0, 100, 200, 550, 550, 2000, 600, 700};
  int exp_zero[NB] = '{0, 0, 0, 0, 0, 0, 0, 0};

  task automatic load_ramp();
    for (int k = 0; k < NB; k++) set_bin(k, 100 * k, 0);
    set_bin(3, 300, 400);
    set_bin(4, 300, 400);
    set_bin(5, 0, -2000);
  endtask

  initial begin
    int found;

    // Reset state.
    for (int k = 0; k < NB; k++) set_bin(k, 0, 0);
    reset = 1'b0;
    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b1;
    step();

    // Frame 1: every bin (1000,0); equal magnitudes keep bin 0 as peak.
    for (int k = 0; k < NB; k++) set_bin(k, 1000, 0);
    clear_log();
    pulse_fft();
    chk("f1 busy during scan", 64'(o_busy), 64'd1);
    wait_frame("f1");
    check_writes("f1", exp_flat);
    chk("f1 busy after done", 64'(o_busy), 64'd0);
    chk("f1 peak_bin", 64'(o_peak_bin), 64'd0);
    chk("f1 peak_mag", 64'(o_peak_mag), 64'd1000);
    chk("f1 overrun", 64'(o_overrun), 64'd0);

    // Frame 2: ramp with a negative-imaginary spike at bin 5.
    load_ramp();
    clear_log();
    pulse_fft();
    for (int i = 0; i < 20 && wr_seen == 0; i++) step();
    chk("f2 peak_mag held mid-frame", 64'(o_peak_mag), 64'd1000);
    wait_frame("f2");
    check_writes("f2", exp_ramp);
    chk("f2 peak_bin", 64'(o_peak_bin), 64'd5);
    chk("f2 peak_mag", 64'(o_peak_mag), 64'd2000);

    // Frame 3: second i_fft_done lands in DRAIN.
    clear_log();
    pulse_fft();
    repeat (9) step();
    chk("f3 in drain (rd_en low)", 64'(o_bin_rd_en), 64'd0);
    i_fft_done = 1'b1;
    step();
    i_fft_done = 1'b0;
    chk("f3 overrun set", 64'(o_overrun), 64'd1);
    chk("f3 still busy", 64'(o_busy), 64'd1);
    wait_frame("f3");
    check_writes("f3", exp_ramp);
    repeat (20) step();
    chk("f3 no second scan reads", 64'(rd_seen), 64'd8);
    chk("f3 no second frame_done", 64'(fd_seen), 64'd1);
    chk("f3 idle afterwards", 64'(o_busy), 64'd0);
    chk("f3 overrun sticky", 64'(o_overrun), 64'd1);

    // Frame 4: reset pulse right after the third read aborts the frame.
    clear_log();
    pulse_fft();
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (o_bin_rd_en && o_bin_rd_addr == AW'(2)) found = 1;
      else step();
    end
    chk("f4 third read reached", 64'(found), 64'd1);
    reset = 1'b0;
    step();
    check_reset_values("f4 mid-scan reset");
    reset = 1'b1;
    clear_log();
    repeat (20) step();
    chk("f4 no writes after abort", 64'(wr_seen), 64'd0);
    chk("f4 no frame_done after abort", 64'(fd_seen), 64'd0);
    chk("f4 no reads after abort", 64'(rd_seen), 64'd0);

    // Frame 5: clean frame after the abort.
    clear_log();
    pulse_fft();
    wait_frame("f5");
    check_writes("f5", exp_ramp);
    chk("f5 peak_bin", 64'(o_peak_bin), 64'd5);
    chk("f5 peak_mag", 64'(o_peak_mag), 64'd2000);

    // Frame 6: all-zero frame; previous peak held until DONE.
    for (int k = 0; k < NB; k++) set_bin(k, 0, 0);
    clear_log();
    pulse_fft();
    for (int i = 0; i < 20 && wr_seen == 0; i++) step();
    chk("f6 peak_bin held mid-frame", 64'(o_peak_bin), 64'd5);
    chk("f6 peak_mag held mid-frame", 64'(o_peak_mag), 64'd2000);
    wait_frame("f6");
    check_writes("f6", exp_zero);
    chk("f6 peak_bin", 64'(o_peak_bin), 64'd0);
    chk("f6 peak_mag", 64'(o_peak_mag), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

endmodule
